// File: rtl/adc_scan_sequencer_if.sv
// Sequencer bundle: APB config and commands, ADC macro controls, sample FIFO handshake and status.
interface adc_scan_sequencer_if;
    logic [7:0]  cfg_mask;
    logic        cfg_scan;
    logic [15:0] cfg_round_num;
    logic        cmd_start;
    logic        cmd_abort;
    logic        conv_valid;
    logic [9:0]  conv_data;
    logic        adc_rstb;
    logic        adc_start;
    logic [7:0]  adc_in_sel;
    logic        smp_valid;
    logic        smp_ready;
    logic [12:0] smp_data;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] round_cnt;

    modport master (
        input  cfg_mask, cfg_scan, cfg_round_num, cmd_start, cmd_abort,
        input  conv_valid, conv_data, smp_ready,
        output adc_rstb, adc_start, adc_in_sel, smp_valid, smp_data,
        output busy, done, timeout_err, round_cnt
    );

    modport slave (
        output cfg_mask, cfg_scan, cfg_round_num, cmd_start, cmd_abort,
        output conv_valid, conv_data, smp_ready,
        input  adc_rstb, adc_start, adc_in_sel, smp_valid, smp_data,
        input  busy, done, timeout_err, round_cnt
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Round-counted ADC scan: reset, select, convert and push one tagged sample per enabled channel.
// Outputs are registered decodes of the next state; PUSH holds smp_data until smp_ready with no limit.
module adc_scan_sequencer #(
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 pclk,
    input  logic                 prst,
    adc_scan_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_SEL, S_CONV, S_PUSH, S_NEXT, S_DONE
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [2:0]  ch, ch_nxt;
    logic [7:0]  mask_q;
    logic        scan_q;
    logic [15:0] rounds_q;
    logic [15:0] round_q, round_nxt;
    logic        pend_q, pend_nxt;
    logic        latch, capture, tmo_set;
    logic [7:0]  hi_bits;

    logic        adc_rstb_q, adc_start_q, smp_valid_q, busy_q, done_q, timeout_err_q;
    logic [7:0]  adc_in_sel_q;
    logic [12:0] smp_data_q;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // enabled channels strictly above the current pointer
    assign hi_bits = mask_q & (8'hFE << ch);

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        round_nxt = round_q;
        pend_nxt  = pend_q;
        latch     = 1'b0;
        capture   = 1'b0;
        tmo_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_q) begin
                    pend_nxt  = 1'b0;
                    state_nxt = S_DONE;
                end else if (bus.cmd_start) begin
                    latch     = 1'b1;
                    ch_nxt    = lowest_bit(bus.cfg_mask);
                    round_nxt = 16'd0;
                    // an empty mask still reports completion, one cycle later, without touching the ADC
                    if (bus.cfg_mask == 8'd0) pend_nxt = 1'b1;
                    else                      state_nxt = S_RST;
                end
            end
            S_RST:  if (cnt == RST_LAST)    state_nxt = S_SEL;
            S_SEL:  if (cnt == SETTLE_LAST) state_nxt = S_CONV;
            S_CONV: begin
                if (bus.conv_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_PUSH;
                end else if (cnt == TMO_LAST) begin
                    tmo_set   = 1'b1;
                    state_nxt = S_NEXT;
                end
            end
            S_PUSH: if (bus.smp_ready) state_nxt = S_NEXT;
            S_NEXT: begin
                if (scan_q && hi_bits != 8'd0) begin
                    ch_nxt = lowest_bit(hi_bits);
                end else begin
                    ch_nxt    = scan_q ? lowest_bit(mask_q) : ch;
                    round_nxt = round_q + 16'd1;
                end
                if (rounds_q != 16'd0 && round_nxt == rounds_q) state_nxt = S_DONE;
                else                                            state_nxt = S_SEL;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.cmd_abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            ch_nxt    = ch;
            round_nxt = round_q;
            capture   = 1'b0;
            tmo_set   = 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state         <= S_IDLE;
            cnt           <= 16'd0;
            ch            <= 3'd0;
            mask_q        <= 8'd0;
            scan_q        <= 1'b0;
            rounds_q      <= 16'd0;
            round_q       <= 16'd0;
            pend_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            smp_data_q    <= 13'd0;
            adc_rstb_q    <= 1'b1;
            adc_start_q   <= 1'b0;
            adc_in_sel_q  <= 8'h80;
            smp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
            ch      <= ch_nxt;
            round_q <= round_nxt;
            pend_q  <= pend_nxt;
            if (latch) begin
                mask_q        <= bus.cfg_mask;
                scan_q        <= bus.cfg_scan;
                rounds_q      <= bus.cfg_round_num;
                timeout_err_q <= 1'b0;
            end else if (tmo_set) begin
                timeout_err_q <= 1'b1;
            end
            if (capture) smp_data_q <= {ch, bus.conv_data};
            adc_rstb_q  <= (state_nxt != S_RST);
            adc_start_q <= (state_nxt == S_CONV);
            smp_valid_q <= (state_nxt == S_PUSH);
            busy_q      <= (state_nxt != S_IDLE);
            done_q      <= (state_nxt == S_DONE);
            if (state_nxt inside {S_SEL, S_CONV, S_PUSH, S_NEXT}) adc_in_sel_q <= 8'd1 << ch_nxt;
            else                                                  adc_in_sel_q <= 8'h80;
        end
    end

    assign bus.adc_rstb    = adc_rstb_q;
    assign bus.adc_start   = adc_start_q;
    assign bus.adc_in_sel  = adc_in_sel_q;
    assign bus.smp_valid   = smp_valid_q;
    assign bus.smp_data    = smp_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.round_cnt   = round_q;
endmodule
